note_scheduler: RTL and testbench
=================================

NOTE_SCHEDULER -- requirements
Module: note_scheduler

Interface
REQ-001 Parameters (name, default, meaning): TICK_DIV 800000 CLOCK_25 cycles per movement tick; Y_START 8 spawn y; Y_HIT 200 hit-line y; HIT_WIN 8 hit half-window; Y_END 240 retire y.
REQ-002 CLOCK_25  in  1  system clock; all logic on rising edge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 start  in  1  one-cycle pulse, begins chart playback from address 0; ignored outside IDLE.
REQ-005 chart_addr  out  8  chart ROM address.
REQ-006 chart_data  in  16  ROM word, valid exactly 1 cycle after chart_addr changes; [15:12] lane mask, [11:0] delay in ticks before spawn.
REQ-007 keys  in  4  lane buttons, already synchronized; bit i = lane i.
REQ-008 slot_active  out  4  slot s holds a live note.
REQ-009 slot_cmd  out  16  slot s lane mask at [4s+3:4s]; 0 when inactive.
REQ-010 slot_y  out  32  slot s y position at [8s+7:8s].
REQ-011 tick  out  1  one-cycle pulse every TICK_DIV cycles.
REQ-012 score  out  16  hit count; miss_cnt  out  16  missed lane bits; busy  out  1  FSM not IDLE; done  out  1  one-cycle pulse at end of chart.

Function
REQ-013 Tick counter counts 0..TICK_DIV-1 and wraps; tick asserts in the cycle the count equals TICK_DIV-1.
REQ-014 FSM states: IDLE, FETCH (drive chart_addr), WAIT_ROM (capture chart_data), DELAY, ALLOC, DRAIN.
REQ-015 IDLE->FETCH on start; FETCH->WAIT_ROM next cycle; WAIT_ROM: word 0x0000 -> DRAIN, else load delay counter -> DELAY.
REQ-016 DELAY decrements on each tick; delay 0 or counter reaching 0 -> ALLOC.
REQ-017 ALLOC loads lowest-index free slot with mask, y=Y_START, active=1; increments chart_addr; -> FETCH. No free slot: stall in ALLOC, no entry dropped.
REQ-018 chart_addr 255 wraps to 0.
REQ-019 On tick every active slot y increments by 1 (8-bit, saturates at Y_END).
REQ-020 Slot retires (active=0, cmd=0) in the cycle its y would reach Y_END; miss_cnt adds popcount of remaining mask bits.
REQ-021 Key rising edge on lane i (registered previous-keys compare) hits lowest-index active slot with cmd bit i set and |y-Y_HIT| <= HIT_WIN: bit cleared, score +1 (saturating at 0xFFFF).
REQ-022 One edge hits at most one slot; simultaneous edges on several lanes are judged independently in the same cycle.
REQ-023 Slot whose mask becomes 0 from hits frees in the same cycle.
REQ-024 Hit and retire on the same slot in the same cycle: hit evaluated on pre-tick y, hit bit not counted as miss.
REQ-025 Edge with no eligible slot: no change (see REQ-029).
REQ-026 DRAIN -> IDLE when slot_active==0; done pulses in that transition cycle.
REQ-027 Slot freed in a cycle is allocatable from the next cycle.

Reset
REQ-028 reset: FSM IDLE, chart_addr 0, all slots inactive with cmd 0 and y 0, tick counter 0, tick 0, score 0, miss_cnt 0, busy 0, done 0, key history 0; mid-playback reset discards all live notes with no miss counting.

Configuration
REQ-029 HIT_PENALTY_EN defined: key edge with no eligible slot decrements score by 1, saturating at 0; undefined: such edges have no effect.

Verification (TICK_DIV=4, Y_START=8, Y_HIT=20, HIT_WIN=2, Y_END=30)
REQ-030 Chart {0x1000, 0x0000}, start, press lane 0 when slot_y[7:0]=20 -> score=1, slot 0 freed, done pulse, miss_cnt=0.
REQ-031 Chart {0x3000, 0x0000}, no keys -> slot 0 retires at y=30, miss_cnt=2, done pulses next cycle.
REQ-032 Chart of five entries 0x1000 -> slots 0..3 fill, fifth stalls in ALLOC until slot 0 retires, then loads into slot 0.
REQ-033 Lane 2 edge at y=17 and at y=23 -> no hit; at y=18 -> hit; with HIT_PENALTY_EN score never goes below 0.
REQ-034 Chart {0x1003, 0x0000}: spawn occurs exactly 3 ticks after WAIT_ROM; reset asserted mid-flight -> all outputs return to REQ-028 values next cycle.

Source files
------------

// File: rtl/note_scheduler.sv
// Rhythm-game note scheduler: plays a chart from ROM into four falling-note slots, judges key hits.
// Optional build macro HIT_PENALTY_EN: a key edge with no eligible note costs one point (floor 0).
module note_scheduler #(
    parameter int unsigned TICK_DIV = 800000,
    parameter int unsigned Y_START  = 8,
    parameter int unsigned Y_HIT    = 200,
    parameter int unsigned HIT_WIN  = 8,
    parameter int unsigned Y_END    = 240
) (
    input  logic        CLOCK_25,
    input  logic        reset,
    input  logic        start,
    output logic [7:0]  chart_addr,
    input  logic [15:0] chart_data,
    input  logic [3:0]  keys,
    output logic [3:0]  slot_active,
    output logic [15:0] slot_cmd,
    output logic [31:0] slot_y,
    output logic        tick,
    output logic [15:0] score,
    output logic [15:0] miss_cnt,
    output logic        busy,
    output logic        done
);
    localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HitLo = int'(Y_HIT) - int'(HIT_WIN);
    localparam int HitHi = int'(Y_HIT) + int'(HIT_WIN);
`ifdef HIT_PENALTY_EN
    localparam int PenW = 1;
`else
    localparam int PenW = 0;
`endif

    typedef enum logic [2:0] {StIdle, StFetch, StWaitRom, StDelay, StAlloc, StDrain} state_e;
    state_e state_q, state_d;

    logic [CntW-1:0] tick_cnt_q, tick_cnt_d;
    logic [7:0]      addr_q, addr_d;
    logic [3:0]      mask_q, mask_d;
    logic [11:0]     delay_q, delay_d;
    logic [3:0]      keys_q;
    logic [3:0]      active_q, active_d;
    logic [3:0]      cmd_q [4];
    logic [3:0]      cmd_d [4];
    logic [7:0]      y_q [4];
    logic [7:0]      y_d [4];
    logic [15:0]     score_q, score_d;
    logic [15:0]     miss_q, miss_d;

    logic            alloc_en, free_any;
    logic [1:0]      free_idx;
    logic [3:0]      in_win, edges, lane_hit;
    int              hit_cnt, pen_cnt, miss_add, score_sum;

    assign tick       = (tick_cnt_q == CntW'(TICK_DIV - 1));
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

    always_comb begin
        free_any = 1'b0;
        free_idx = '0;
        for (int s = 3; s >= 0; s--) begin
            if (!active_q[s]) begin
                free_any = 1'b1;
                free_idx = 2'(s);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        mask_d   = mask_q;
        delay_d  = delay_q;
        alloc_en = 1'b0;
        done     = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    addr_d  = '0;
                    state_d = StFetch;
                end
            end
            StFetch:   state_d = StWaitRom;
            StWaitRom: begin
                if (chart_data == 16'h0000) begin
                    state_d = StDrain;
                end else begin
                    mask_d  = chart_data[15:12];
                    delay_d = chart_data[11:0];
                    state_d = StDelay;
                end
            end
            StDelay: begin
                if (delay_q == 12'd0) begin
                    state_d = StAlloc;
                end else if (tick) begin
                    delay_d = delay_q - 12'd1;
                    if (delay_q == 12'd1) state_d = StAlloc;
                end
            end
            StAlloc: begin
                // An empty lane mask is a pure rest: advance without occupying a slot.
                if (mask_q == 4'd0 || free_any) begin
                    alloc_en = (mask_q != 4'd0);
                    addr_d   = addr_q + 8'd1;
                    state_d  = StFetch;
                end
            end
            StDrain: begin
                if (active_q == 4'd0) begin
                    done    = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        for (int s = 0; s < 4; s++) begin
            in_win[s] = (int'(y_q[s]) >= HitLo) && (int'(y_q[s]) <= HitHi);
        end
    end

    always_comb begin
        edges    = keys & ~keys_q;
        active_d = active_q;
        cmd_d    = cmd_q;
        y_d      = y_q;
        lane_hit = '0;
        hit_cnt  = 0;
        pen_cnt  = 0;
        miss_add = 0;
        // Each lane edge claims at most one note, lowest slot first, judged on pre-tick y.
        for (int i = 0; i < 4; i++) begin
            for (int s = 0; s < 4; s++) begin
                if (edges[i] && !lane_hit[i] && active_q[s] && cmd_q[s][i] && in_win[s]) begin
                    lane_hit[i] = 1'b1;
                    cmd_d[s][i] = 1'b0;
                end
            end
            if (lane_hit[i]) hit_cnt = hit_cnt + 1;
            else if (edges[i]) pen_cnt = pen_cnt + 1;
        end
        for (int s = 0; s < 4; s++) begin
            if (active_q[s]) begin
                if (cmd_d[s] == 4'd0) begin
                    active_d[s] = 1'b0;
                end else if (tick) begin
                    if (int'(y_q[s]) + 1 >= int'(Y_END)) begin
                        for (int b = 0; b < 4; b++) begin
                            if (cmd_d[s][b]) miss_add = miss_add + 1;
                        end
                        active_d[s] = 1'b0;
                        cmd_d[s]    = 4'd0;
                        y_d[s]      = 8'(Y_END);
                    end else begin
                        y_d[s] = y_q[s] + 8'd1;
                    end
                end
            end
        end
        if (alloc_en) begin
            active_d[free_idx] = 1'b1;
            cmd_d[free_idx]    = mask_q;
            y_d[free_idx]      = 8'(Y_START);
        end
        score_sum = int'(score_q) + hit_cnt - PenW * pen_cnt;
        if (score_sum > 65535)  score_d = 16'hFFFF;
        else if (score_sum < 0) score_d = 16'h0000;
        else                    score_d = 16'(score_sum);
        miss_d = miss_q + 16'(miss_add);
    end

    always_ff @(posedge CLOCK_25) begin
        if (reset) begin
            state_q    <= StIdle;
            tick_cnt_q <= '0;
            addr_q     <= '0;
            mask_q     <= '0;
            delay_q    <= '0;
            keys_q     <= '0;
            active_q   <= '0;
            score_q    <= '0;
            miss_q     <= '0;
            for (int s = 0; s < 4; s++) begin
                cmd_q[s] <= '0;
                y_q[s]   <= '0;
            end
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            addr_q     <= addr_d;
            mask_q     <= mask_d;
            delay_q    <= delay_d;
            keys_q     <= keys;
            active_q   <= active_d;
            score_q    <= score_d;
            miss_q     <= miss_d;
            cmd_q      <= cmd_d;
            y_q        <= y_d;
        end
    end

    always_comb begin
        slot_cmd = '0;
        slot_y   = '0;
        for (int s = 0; s < 4; s++) begin
            slot_cmd[4*s +: 4] = cmd_q[s];
            slot_y[8*s +: 8]   = y_q[s];
        end
    end

    assign chart_addr  = addr_q;
    assign slot_active = active_q;
    assign score       = score_q;
    assign miss_cnt    = miss_q;
    assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_note_scheduler.sv
// Directed bench for note_scheduler with a registered chart ROM model and small tick divider.
module tb_note_scheduler;
    logic        clk = 1'b0;
    logic        reset, start;
    logic [7:0]  chart_addr;
    logic [15:0] chart_data;
    logic [3:0]  keys;
    logic [3:0]  slot_active;
    logic [15:0] slot_cmd;
    logic [31:0] slot_y;
    logic        tick;
    logic [15:0] score, miss_cnt;
    logic        busy, done;

    logic [15:0] rom [256];
    int n_tests, n_fail;

    note_scheduler #(
        .TICK_DIV(4), .Y_START(8), .Y_HIT(20), .HIT_WIN(2), .Y_END(30)
    ) dut (
        .CLOCK_25(clk), .reset(reset), .start(start), .chart_addr(chart_addr),
        .chart_data(chart_data), .keys(keys), .slot_active(slot_active), .slot_cmd(slot_cmd),
        .slot_y(slot_y), .tick(tick), .score(score), .miss_cnt(miss_cnt), .busy(busy),
        .done(done)
    );

    always #20 clk = ~clk;
    always @(posedge clk) chart_data <= rom[chart_addr];

    typedef struct {
        logic [3:0]  mask;
        logic [3:0]  keys;
        logic [7:0]  press_y;
        logic [15:0] score;
        logic [3:0]  active;
        logic [3:0]  cmd;
        logic        done;
    } vec_t;
    vec_t vecs [9];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        keys  = 4'd0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    endtask

    initial begin
        int  ticks;
        bit  found;
        n_tests = 0;
        n_fail  = 0;
        reset = 1'b1;
        start = 1'b0;
        keys  = 4'd0;
        clear_rom();
        // mask, keys, press y, score, slot_active, slot_cmd, done
        vecs[0] = '{4'h1, 4'h1, 8'd20, 16'd1, 4'h0, 4'h0, 1'b1};
        vecs[1] = '{4'h4, 4'h4, 8'd17, 16'd0, 4'h1, 4'h4, 1'b0};
        vecs[2] = '{4'h4, 4'h4, 8'd23, 16'd0, 4'h1, 4'h4, 1'b0};
        vecs[3] = '{4'h4, 4'h4, 8'd18, 16'd1, 4'h0, 4'h0, 1'b1};
        vecs[4] = '{4'h4, 4'h4, 8'd22, 16'd1, 4'h0, 4'h0, 1'b1};
        vecs[5] = '{4'h3, 4'h1, 8'd20, 16'd1, 4'h1, 4'h2, 1'b0};
        vecs[6] = '{4'h3, 4'h3, 8'd19, 16'd2, 4'h0, 4'h0, 1'b1};
        vecs[7] = '{4'h1, 4'h2, 8'd20, 16'd0, 4'h1, 4'h1, 1'b0};
        vecs[8] = '{4'h8, 4'h8, 8'd21, 16'd1, 4'h0, 4'h0, 1'b1};

        // Reset state and tick cadence
        do_reset();
        check("rst chart_addr", chart_addr, 0);
        check("rst slot_active", slot_active, 0);
        check("rst slot_cmd", slot_cmd, 0);
        check("rst slot_y", slot_y, 0);
        check("rst tick", tick, 0);
        check("rst score", score, 0);
        check("rst miss_cnt", miss_cnt, 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        step(); check("tick c1", tick, 0);
        step(); check("tick c2", tick, 0);
        step(); check("tick c3", tick, 1);
        step(); check("tick c4", tick, 0);

        // Table: single note, keys pressed when slot 0 reaches press_y
        for (int v = 0; v < 9; v++) begin
            clear_rom();
            rom[0] = {vecs[v].mask, 12'd0};
            do_reset();
            start = 1'b1;
            step();
            start = 1'b0;
            found = 1'b0;
            for (int c = 0; c < 400 && !found; c++) begin
                if (slot_active[0] && slot_y[7:0] == vecs[v].press_y) found = 1'b1;
                else step();
            end
            if (!found) begin
                timeout($sformatf("v%0d reach y", v));
            end else begin
                keys = vecs[v].keys;
                step();
                keys = 4'd0;
                check($sformatf("v%0d score", v), score, vecs[v].score);
                check($sformatf("v%0d slot_active", v), slot_active, vecs[v].active);
                check($sformatf("v%0d slot_cmd", v), slot_cmd, vecs[v].cmd);
                check($sformatf("v%0d done", v), done, vecs[v].done);
                check($sformatf("v%0d miss_cnt", v), miss_cnt, 0);
            end
        end

        // Unhit two-lane note retires at Y_END and counts two misses
        clear_rom();
        rom[0] = 16'h3000;
        do_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
            if (slot_active[0]) found = 1'b1;
            else step();
        end
        for (int c = 0; c < 400 && found && slot_active[0]; c++) step();
        if (!found || slot_active[0]) begin
            timeout("retire");
        end else begin
            check("retire y", slot_y[7:0], 30);
            check("retire cmd", slot_cmd, 0);
            check("retire miss_cnt", miss_cnt, 2);
            check("retire done", done, 1);
            step();
            check("retire done after", done, 0);
            check("retire busy after", busy, 0);
        end

        // Delay of 3 ticks, then synchronous reset mid-flight
        clear_rom();
        rom[0] = 16'h1003;
        do_reset();
        start = 1'b1;
        ticks = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            start = 1'b0;
            if (tick) ticks++;
        end
        check("delay ticks seen", ticks, 3);
        check("delay no spawn yet", slot_active, 0);
        step();
        check("delay spawn active", slot_active, 1);
        check("delay spawn y", slot_y[7:0], 8);
        check("delay spawn cmd", slot_cmd, 16'h0001);
        step();
        step();
        check("midflight busy", busy, 1);
        check("midflight chart_addr", chart_addr, 1);
        reset = 1'b1;
        step();
        check("mid rst chart_addr", chart_addr, 0);
        check("mid rst slot_active", slot_active, 0);
        check("mid rst slot_cmd", slot_cmd, 0);
        check("mid rst slot_y", slot_y, 0);
        check("mid rst tick", tick, 0);
        check("mid rst score", score, 0);
        check("mid rst miss_cnt", miss_cnt, 0);
        check("mid rst busy", busy, 0);
        check("mid rst done", done, 0);
        reset = 1'b0;

        // Five notes: fifth stalls until slot 0 retires
        clear_rom();
        for (int i = 0; i < 5; i++) rom[i] = 16'h1000;
        do_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            if (slot_active == 4'hF) found = 1'b1;
            else step();
        end
        if (!found) begin
            timeout("fill slots");
        end else begin
            for (int k = 0; k < 6; k++) step();
            check("stall slot_active", slot_active, 4'hF);
            check("stall chart_addr", chart_addr, 4);
            check("stall busy", busy, 1);
            for (int c = 0; c < 400 && slot_active == 4'hF; c++) step();
            if (slot_active == 4'hF) begin
                timeout("stall release");
            end else begin
                check("free slot_active", slot_active, 4'hE);
                check("free miss_cnt", miss_cnt, 1);
                step();
                check("refill slot_active", slot_active, 4'hF);
                check("refill y0", slot_y[7:0], 8);
                check("refill cmd0", slot_cmd[3:0], 1);
                check("refill chart_addr", chart_addr, 5);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
